datapath_ctrl: RTL
==================

DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 No parameters.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high; forces all state and outputs to reset values.
REQ-004 in_valid  in  1  instruction on instr is offered.
REQ-005 instr  in  16  instruction: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm, [7:0] imm8.
REQ-006 in_ready  out  1  controller accepts instr this cycle.
REQ-007 done  out  1  one-cycle pulse when an accepted instruction retires.
REQ-008 err  out  1  illegal-opcode indicator; see Configuration.
REQ-009 readnum, writenum  out  3 each  register-file read and write indices.
REQ-010 loada, loadb, loadc, loads, write  out  1 each  datapath load and write enables.
REQ-011 asel, bsel, vsel  out  1 each  operand and writeback selects; asel=1 forces A to 0; vsel=1 selects datapath_in, vsel=0 selects C.
REQ-012 shift, ALUop  out  2 each  shifter code and ALU code (00 ADD, 01 SUB, 10 AND, 11 NOT B).
REQ-013 datapath_in  out  16  immediate sign-extended from imm8.

Function
REQ-014 States: IDLE, WRIMM, GETA, GETB, EXEC, WRITE, DONE, HALT.
REQ-015 in_ready SHALL be 1 only in IDLE. A transfer occurs when in_valid & in_ready; instr is then captured into IR.
REQ-016 Decode from IR:
- 110/10 MOV imm
- 110/00 MOV reg
- 101/00 ADD
- 101/01 CMP
- 101/10 AND
- 101/11 MVN
- all other opcode/op pairs are illegal.
REQ-017 Transitions out of IDLE on transfer:
- MOV imm -> WRIMM
- ADD, CMP, AND -> GETA
- MOV reg, MVN -> GETB
- illegal -> HALT if ILLEGAL_TRAP_EN, otherwise -> DONE
REQ-018 Transitions:
- WRIMM -> DONE
- GETA -> GETB
- GETB -> EXEC
- EXEC -> DONE for CMP, otherwise -> WRITE
- WRITE -> DONE
- DONE -> IDLE
- HALT -> HALT
REQ-019 Per-state outputs (unlisted enables are 0):
- WRIMM: writenum=Rn, vsel=1, write=1, datapath_in=sign-extended imm8
- GETA: readnum=Rn, loada=1
- GETB: readnum=Rm, loadb=1
- EXEC: shift=sh, bsel=0, loadc=1; asel=1 for MOV reg and MVN, else 0; ALUop=00 for MOV reg, else op; loads=1 for CMP only
- WRITE: writenum=Rd, vsel=0, write=1
- DONE: done=1
REQ-020 Outputs SHALL be combinational functions of state and IR only, never of in_valid or instr directly.
REQ-021 Latency from the acceptance cycle T, done at:
- MOV imm: T+2
- MOV reg, MVN: T+4
- CMP: T+4
- ADD, AND: T+5
- illegal without trap: T+1
REQ-022 A new instruction SHALL NOT be accepted before the cycle after done; back-to-back transfers are spaced by exactly one IDLE cycle.
REQ-023 When not in its active state, every enable SHALL be 0. Index, select and code outputs SHALL be 0, and datapath_in SHALL be 0.
REQ-024 instr changes while busy SHALL have no effect.
REQ-025 At most one of loada, loadb, loadc and write SHALL be 1 in any cycle.

Reset
REQ-026 Asserting reset at any time SHALL immediately force IDLE and IR=0, with all outputs 0 except in_ready=1; err=0.
REQ-027 Reset asserted mid-instruction SHALL abort it with no further write, loadc, loads or done.
REQ-028 The first transfer SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro DPCTRL_ILLEGAL_TRAP_EN.
REQ-030 When the macro is defined, an illegal instruction SHALL:
- enter HALT
- set err=1 sticky
- hold in_ready=0 and all enables 0 until reset
- produce no done pulse
REQ-031 When the macro is undefined, an illegal instruction SHALL be a NOP: DONE at T+1 with no datapath enable asserted, and err SHALL be tied 0.

Verification
REQ-032 MOV imm: instr=0xD0FB (MOV R0,#-5) -> T+1: write=1, writenum=0, vsel=1, datapath_in=0xFFFB; done at T+2.
REQ-033 ADD: instr=0xA148 (R2=R1+R0 LSL1) -> GETA readnum=1, GETB readnum=0, EXEC shift=01 ALUop=00 loadc=1 loads=0, WRITE writenum=2; done at T+5.
REQ-034 CMP: instr=0xA900 (Rn=1, Rm=0) -> EXEC ALUop=01 loads=1, no write cycle; done at T+4.
REQ-035 Handshake: in_valid held high with two queued instrs -> second accepted exactly one cycle after the first's done; instr toggled mid-op leaves outputs unchanged.
REQ-036 Reset in EXEC of ADD -> next cycle IDLE, in_ready=1, write never asserted, no done.
REQ-037 Illegal instr=0xE000 -> with the macro: err=1, in_ready=0, no done until reset; without it: done at T+1, no enables, err=0.

Source files
------------

// File: rtl/datapath_ctrl.sv
// Instruction-sequencing controller for a simple register-file/ALU datapath.
// Optional DPCTRL_ILLEGAL_TRAP_EN: illegal opcodes halt with a sticky err instead of retiring as a NOP.
module datapath_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] instr,
  output logic        in_ready,
  output logic        done,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] datapath_in
);

  localparam int unsigned IW = 16;
  localparam int unsigned RW = 3;

  typedef enum logic [2:0] {IDLE, WRIMM, GETA, GETB, EXEC, WRITE, DONE, HALT} state_t;
  typedef enum logic [2:0] {K_ILL, K_MOVI, K_MOVR, K_ADD, K_CMP, K_AND, K_MVN} kind_t;

  // Classify an {opcode, op} pair.
  function automatic kind_t decode(input logic [4:0] opc);
    case (opc)
      5'b110_10: decode = K_MOVI;
      5'b110_00: decode = K_MOVR;
      5'b101_00: decode = K_ADD;
      5'b101_01: decode = K_CMP;
      5'b101_10: decode = K_AND;
      5'b101_11: decode = K_MVN;
      default:   decode = K_ILL;
    endcase
  endfunction

  state_t        state, state_nxt;
  logic [IW-1:0] ir;
  kind_t         in_kind, ir_kind;
  logic          take;

  assign in_kind = decode(instr[15:11]);
  assign ir_kind = decode(ir[15:11]);
  assign take    = in_valid && (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (take) ir <= instr;
    end
  end

  // Next state and all outputs; outputs depend only on state and IR.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    readnum     = '0;
    writenum    = '0;
    loada       = 1'b0;
    loadb       = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    write       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    vsel        = 1'b0;
    shift       = '0;
    ALUop       = '0;
    datapath_in = '0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          case (in_kind)
            K_MOVI:              state_nxt = WRIMM;
            K_ADD, K_CMP, K_AND: state_nxt = GETA;
            K_MOVR, K_MVN:       state_nxt = GETB;
`ifdef DPCTRL_ILLEGAL_TRAP_EN
            default:             state_nxt = HALT;
`else
            default:             state_nxt = DONE;
`endif
          endcase
        end
      end
      WRIMM: begin
        writenum    = RW'(ir[10:8]);
        vsel        = 1'b1;
        write       = 1'b1;
        datapath_in = IW'({{8{ir[7]}}, ir[7:0]});
        state_nxt   = DONE;
      end
      GETA: begin
        readnum   = RW'(ir[10:8]);
        loada     = 1'b1;
        state_nxt = GETB;
      end
      GETB: begin
        readnum   = RW'(ir[2:0]);
        loadb     = 1'b1;
        state_nxt = EXEC;
      end
      EXEC: begin
        shift     = ir[4:3];
        loadc     = 1'b1;
        asel      = (ir_kind == K_MOVR) || (ir_kind == K_MVN);
        ALUop     = (ir_kind == K_MOVR) ? 2'b00 : ir[12:11];
        loads     = (ir_kind == K_CMP);
        state_nxt = (ir_kind == K_CMP) ? DONE : WRITE;
      end
      WRITE: begin
        writenum  = RW'(ir[7:5]);
        write     = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      HALT: begin
`ifdef DPCTRL_ILLEGAL_TRAP_EN
        err = 1'b1;
`endif
        state_nxt = HALT;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
